// File: rtl/run_pattern_generator.sv
// run_pattern_generator
// Serial stimulus source for the zero-detector path. An accepted start emits
// N ones followed by one terminating zero on x_out_o, together with the
// expected Mealy detector response on exp_y_o.
//
// Optional feature macro: RUN_GEN_REPEAT_EN adds repeat_i, which chains
// patterns back to back (period N+1) instead of returning to IDLE.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   start_i    pattern request, accepted only while ready_o=1
//   run_len_i  run length N, sampled with an accepted start
//   repeat_i   (RUN_GEN_REPEAT_EN only) restart from ZERO when N != 0
//   ready_o    idle, able to accept start
//   busy_o     pattern in progress (always ~ready_o)
//   x_out_o    serial pattern bit, drives the detector x_in
//   done_o     one-cycle pulse during the terminating-zero cycle
//   exp_y_o    expected detector output, 1 in the zero cycle when N >= 1
//   pkt_cnt_o  completed-pattern counter, wraps modulo 2^PKT_W
module run_pattern_generator #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned PKT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] run_len_i,
`ifdef RUN_GEN_REPEAT_EN
    input  logic             repeat_i,
`endif
    output logic             ready_o,
    output logic             busy_o,
    output logic             x_out_o,
    output logic             done_o,
    output logic             exp_y_o,
    output logic [PKT_W-1:0] pkt_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONES = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   len_q;
    logic               x_q;
    logic               done_q;
    logic               exp_y_q;
    logic               ready_q;
    logic               busy_q;
    logic [PKT_W-1:0]   pkt_q;
    logic               repeat_c;

    // Restart request seen in ZERO; tied off when the feature is absent.
`ifdef RUN_GEN_REPEAT_EN
    assign repeat_c = repeat_i;
`else
    assign repeat_c = 1'b0;
`endif

    // Single-process Moore FSM; every output is a register written alongside
    // the state transition that produces it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
            exp_y_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= run_len_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (run_len_i != '0) begin
                            cnt_q   <= run_len_i - CNT_W'(1);
                            x_q     <= 1'b1;
                            state_q <= ST_ONES;
                        end else begin
                            // Lone zero: no preceding one, so no detection.
                            x_q     <= 1'b0;
                            done_q  <= 1'b1;
                            exp_y_q <= 1'b0;
                            state_q <= ST_ZERO;
                        end
                    end
                end

                ST_ONES: begin
                    if (cnt_q == '0) begin
                        x_q     <= 1'b0;
                        done_q  <= 1'b1;
                        exp_y_q <= (len_q != '0);
                        state_q <= ST_ZERO;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_ZERO: begin
                    pkt_q   <= pkt_q + PKT_W'(1);
                    done_q  <= 1'b0;
                    exp_y_q <= 1'b0;
                    if (repeat_c && (len_q != '0)) begin
                        // Chain straight into the next run, skipping IDLE.
                        cnt_q   <= len_q - CNT_W'(1);
                        x_q     <= 1'b1;
                        state_q <= ST_ONES;
                    end else begin
                        x_q     <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    x_q     <= 1'b0;
                    done_q  <= 1'b0;
                    exp_y_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign x_out_o   = x_q;
    assign done_o    = done_q;
    assign exp_y_o   = exp_y_q;
    assign pkt_cnt_o = pkt_q;

endmodule

// File: tb/tb_run_pattern_generator.sv
// tb_run_pattern_generator
// Self-checking bench for run_pattern_generator. A queue-based reference model
// expands each accepted request into its per-cycle output stream; a Mealy
// zero-detector model (y = previous x & ~x) cross-checks exp_y_o.
module tb_run_pattern_generator;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PKT_W = 8;
`ifdef RUN_GEN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        logic x;
        logic d;
        logic e;
        logic r;
        int   n;
    } cyc_t;

    logic             clock;
    logic             reset;
    logic             start_i;
    logic [CNT_W-1:0] run_len_i;
    logic             repeat_i;
    logic             ready_o;
    logic             busy_o;
    logic             x_out_o;
    logic             done_o;
    logic             exp_y_o;
    logic [PKT_W-1:0] pkt_cnt_o;

    int tests;
    int fails;

    cyc_t       q[$];
    cyc_t       cur;
    logic [PKT_W-1:0] pkt_m;
    logic       prev_x;

    run_pattern_generator #(.CNT_W(CNT_W), .PKT_W(PKT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start_i   (start_i),
        .run_len_i (run_len_i),
`ifdef RUN_GEN_REPEAT_EN
        .repeat_i  (repeat_i),
`endif
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .x_out_o   (x_out_o),
        .done_o    (done_o),
        .exp_y_o   (exp_y_o),
        .pkt_cnt_o (pkt_cnt_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic cyc_t idle_c();
        cyc_t c;
        c.x = 1'b0; c.d = 1'b0; c.e = 1'b0; c.r = 1'b1; c.n = 0;
        return c;
    endfunction

    // Append one full pattern of n ones plus its terminating zero.
    task automatic push_pattern(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.x = 1'b1; c.d = 1'b0; c.e = 1'b0; c.r = 1'b0; c.n = n;
            q.push_back(c);
        end
        c.x = 1'b0; c.d = 1'b1; c.e = (n != 0); c.r = 1'b0; c.n = n;
        q.push_back(c);
    endtask

    task automatic check_outputs();
        chk("x_out",   32'(x_out_o),   32'(cur.x));
        chk("done",    32'(done_o),    32'(cur.d));
        chk("exp_y",   32'(exp_y_o),   32'(cur.e));
        chk("ready",   32'(ready_o),   32'(cur.r));
        chk("busy",    32'(busy_o),    32'(!cur.r));
        chk("pkt_cnt", 32'(pkt_cnt_o), 32'(pkt_m));
        chk("detector", 32'(exp_y_o),  32'(prev_x & ~x_out_o));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input logic s, input int len, input logic rep);
        logic acc;
        start_i   = s;
        run_len_i = CNT_W'(len);
        repeat_i  = rep;
        acc = s && cur.r;
        prev_x = x_out_o;
        @(posedge clock);
        #1;
        if (cur.d) begin
            pkt_m = pkt_m + PKT_W'(1);
            if (REP_EN && rep && cur.n != 0)
                push_pattern(cur.n);
        end
        if (acc)
            push_pattern(len);
        if (q.size() != 0) cur = q.pop_front();
        else               cur = idle_c();
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q.delete();
        cur    = idle_c();
        pkt_m  = '0;
        prev_x = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        start_i = 1'b0;
        run_len_i = '0;
        repeat_i = 1'b0;
        reset = 1'b1;
        #2;
        do_reset();
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_x",     32'(x_out_o), 32'd0);
        chk("reset_pkt",   32'(pkt_cnt_o), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // N=3 pattern: ones in cycles 1-3, zero+done in 4, ready in 5.
        step(1'b1, 3, 1'b0);
        chk("n3_c1_x", 32'(x_out_o), 32'd1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("n3_c4_done", 32'(done_o), 32'd1);
        chk("n3_c4_expy", 32'(exp_y_o), 32'd1);
        step(1'b0, 0, 1'b0);
        chk("n3_c5_ready", 32'(ready_o), 32'd1);
        chk("n3_pkt", 32'(pkt_cnt_o), 32'd1);

        // N=0: lone zero with done, no expected detection.
        step(1'b1, 0, 1'b0);
        chk("n0_done", 32'(done_o), 32'd1);
        chk("n0_expy", 32'(exp_y_o), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("n0_pkt", 32'(pkt_cnt_o), 32'd2);

        // Start with N=5 while an N=2 pattern is running is ignored.
        step(1'b1, 2, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b1, 5, 1'b0);
        chk("busy_zero", 32'(done_o), 32'd1);
        step(1'b0, 5, 1'b0);
        chk("busy_pkt", 32'(pkt_cnt_o), 32'd3);
        step(1'b0, 0, 1'b0);
        chk("busy_idle", 32'(ready_o), 32'd1);

        // Maximum run length counts all the way down.
        step(1'b1, 15, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 0, 1'b0);
        chk("max_pkt", 32'(pkt_cnt_o), 32'd4);

        // Reset in cycle 2 of an N=4 pattern truncates it.
        step(1'b1, 4, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("pre_rst_x", 32'(x_out_o), 32'd1);
        do_reset();
        chk("rst_mid_x",     32'(x_out_o), 32'd0);
        chk("rst_mid_done",  32'(done_o), 32'd0);
        chk("rst_mid_pkt",   32'(pkt_cnt_o), 32'd0);
        chk("rst_mid_ready", 32'(ready_o), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);

        // 256 back-to-back N=1 patterns wrap the packet counter.
        for (int i = 0; i < 256 * 3; i++) step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("wrap_pkt", 32'(pkt_cnt_o), 32'd0);

`ifdef RUN_GEN_REPEAT_EN
        // Repeat mode: continuous 1,1,0 with done every third cycle.
        step(1'b1, 2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 1'b1);
            chk("rep_busy", 32'(busy_o), 32'd1);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0);
        chk("rep_stop", 32'(ready_o), 32'd1);
`endif

        // Randomised requests against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
